uart_receive: RTL and testbench

16x-oversampling UART receiver for 8N1 frames: the receive-side counterpart to the UART transmit stage, sharing its 16x sample tick and frame format. It synchronises the asynchronous serial line, qualifies the start bit, recovers eight data bits LSB first and checks the stop bit. It delivers one byte per frame with a single-cycle strobe, or a framing-error strobe.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_receive.sv | 134 +++++++++++++
 tb/tb_uart_receive.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling indices and one-hot state encodings
// for both the receive and transmit directions.
package uart_pkg;

  localparam int unsigned SMP_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BIT_W  = 3;

  localparam logic [SMP_W-1:0] SMP_TOP    = 4'd15;
  localparam logic [SMP_W-1:0] SMP_CENTER = 4'd7;
  // Neighbouring samples around the centre used by the majority voter
  localparam logic [SMP_W-1:0] SMP_PRE    = 4'd6;
  localparam logic [SMP_W-1:0] SMP_POST   = 4'd8;

  typedef enum logic [4:0] {
    R_IDLE  = 5'b00001,
    R_START = 5'b00010,
    R_DATA  = 5'b00100,
    R_STOP  = 5'b01000,
    R_BREAK = 5'b10000
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE = 2'b01,
    T_SEND = 2'b10
  } tx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// reset to RST_VAL so an idle-high line never looks active out of reset.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receive.sv
// 16x-oversampling 8N1 UART receiver with start qualification and framing check.
// Define UART_RX_MAJORITY_EN to vote each bit over samples 6/7/8.
module uart_receive
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_16_i,
  input  logic              rxd_i,
  output logic [DATA_W-1:0] rxd_data_o,
  output logic              rxd_flag_o,
  output logic              frame_err_o,
  output logic              rx_busy_o
);

  logic              rxd_s;
  rx_state_e         state_q;
  logic [SMP_W-1:0]  smp_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] rxd_data_q;
  logic              rxd_flag_q;
  logic              frame_err_q;
  logic              eval_c;
  logic              bit_c;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd_i),
    .q_o (rxd_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic smp_pre_q;
  logic smp_ctr_q;

  // Capture the two earlier votes; the third is the live sample at SMP_POST
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_pre_q <= 1'b1;
      smp_ctr_q <= 1'b1;
    end else if (clk_16_i) begin
      if (smp_cnt_q == SMP_PRE)    smp_pre_q <= rxd_s;
      if (smp_cnt_q == SMP_CENTER) smp_ctr_q <= rxd_s;
    end
  end

  assign eval_c = clk_16_i && (smp_cnt_q == SMP_POST);
  assign bit_c  = majority3(smp_pre_q, smp_ctr_q, rxd_s);
`else
  assign eval_c = clk_16_i && (smp_cnt_q == SMP_CENTER);
  assign bit_c  = rxd_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= R_IDLE;
      smp_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rxd_data_q  <= '0;
      rxd_flag_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rxd_flag_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        R_IDLE: begin
          smp_cnt_q <= '0;
          bit_cnt_q <= '0;
          if (clk_16_i && !rxd_s) state_q <= R_START;
        end
        R_START: begin
          if (clk_16_i) begin
            smp_cnt_q <= smp_cnt_q + 4'd1;
            // A high mid-start sample means the edge was a glitch
            if (eval_c && bit_c) begin
              smp_cnt_q <= '0;
              state_q   <= R_IDLE;
            end else if (smp_cnt_q == SMP_TOP) begin
              state_q <= R_DATA;
            end
          end
        end
        R_DATA: begin
          if (clk_16_i) begin
            smp_cnt_q <= smp_cnt_q + 4'd1;
            if (eval_c) shift_q <= {bit_c, shift_q[DATA_W-1:1]};
            if (smp_cnt_q == SMP_TOP) begin
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q <= '0;
                state_q   <= R_STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
        end
        R_STOP: begin
          if (clk_16_i) begin
            smp_cnt_q <= smp_cnt_q + 4'd1;
            // Leaving at mid-stop keeps half a bit of margin for the next start edge
            if (eval_c) begin
              smp_cnt_q <= '0;
              if (bit_c) begin
                rxd_data_q <= shift_q;
                rxd_flag_q <= 1'b1;
                state_q    <= R_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= R_BREAK;
              end
            end
          end
        end
        R_BREAK: begin
          if (clk_16_i && rxd_s) state_q <= R_IDLE;
        end
        default: begin
          smp_cnt_q <= '0;
          bit_cnt_q <= '0;
          state_q   <= R_IDLE;
        end
      endcase
    end
  end

  assign rxd_data_o  = rxd_data_q;
  assign rxd_flag_o  = rxd_flag_q;
  assign frame_err_o = frame_err_q;
  assign rx_busy_o   = (state_q != R_IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// Directed self-checking bench for uart_receive: good frames, back-to-back,
// start glitch, framing error/break, mid-frame reset and a mid-bit glitch.
module tb_uart_receive;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_16_i = 1'b0;
  logic       rxd_i = 1'b1;
  logic [7:0] rxd_data_o;
  logic       rxd_flag_o;
  logic       frame_err_o;
  logic       rx_busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int div = 0;

  int         flag_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         wide_cnt = 0;
  int         flag_cyc = 0;
  logic       prev_flag = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] cap [0:15];

  int t_start;
  int exp_lat;

  uart_receive dut (
    .clk         (clk),
    .rst         (rst),
    .clk_16_i    (clk_16_i),
    .rxd_i       (rxd_i),
    .rxd_data_o  (rxd_data_o),
    .rxd_flag_o  (rxd_flag_o),
    .frame_err_o (frame_err_o),
    .rx_busy_o   (rx_busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 16x tick: one clk high out of every ten
  always @(posedge clk) begin
    if (div == 9) begin
      div      <= 0;
      clk_16_i <= 1'b1;
    end else begin
      div      <= div + 1;
      clk_16_i <= 1'b0;
    end
  end

  // Strobe monitor
  always @(negedge clk) begin
    if (rxd_flag_o) begin
      flag_cnt = flag_cnt + 1;
      flag_cyc = cyc;
      if (flag_cnt < 16) cap[flag_cnt] = rxd_data_o;
    end
    if (frame_err_o) err_cnt = err_cnt + 1;
    if (rxd_flag_o && frame_err_o) both_cnt = both_cnt + 1;
    if ((rxd_flag_o && prev_flag) || (frame_err_o && prev_err)) wide_cnt = wide_cnt + 1;
    prev_flag = rxd_flag_o;
    prev_err  = frame_err_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (clk_16_i !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_i = f[i];
      wait_ticks(16);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) cap[i] = 8'h00;
`ifdef UART_RX_MAJORITY_EN
    exp_lat = 1540;
`else
    exp_lat = 1530;
`endif

    repeat (5) @(negedge clk);
    check_eq("reset_data", 32'(rxd_data_o), 32'h00);
    check_eq("reset_flag", 32'(rxd_flag_o), 32'h0);
    check_eq("reset_err",  32'(frame_err_o), 32'h0);
    check_eq("reset_busy", 32'(rx_busy_o), 32'h0);
    rst = 1'b0;
    wait_ticks(3);

    // Single good frame with latency measurement
    t_start = cyc;
    send_frame(8'hA5, 1'b1);
    wait_ticks(4);
    check_eq("a5_flag_cnt", 32'(flag_cnt), 32'd1);
    check_eq("a5_data",     32'(rxd_data_o), 32'hA5);
    check_eq("a5_cap",      32'(cap[1]), 32'hA5);
    check_eq("a5_err_cnt",  32'(err_cnt), 32'd0);
    check_eq("a5_latency",  32'(flag_cyc - t_start), 32'(exp_lat));
    check_eq("a5_idle",     32'(rx_busy_o), 32'h0);

    // Back-to-back frames, one stop bit between them
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_ticks(4);
    check_eq("b2b_flag_cnt", 32'(flag_cnt), 32'd3);
    check_eq("b2b_first",    32'(cap[2]), 32'h00);
    check_eq("b2b_second",   32'(cap[3]), 32'hFF);
    check_eq("b2b_err_cnt",  32'(err_cnt), 32'd0);

    // Short low glitch must be rejected at mid-start
    rxd_i = 1'b0;
    wait_ticks(4);
    check_eq("glitch_busy", 32'(rx_busy_o), 32'h1);
    rxd_i = 1'b1;
    wait_ticks(20);
    check_eq("glitch_idle",     32'(rx_busy_o), 32'h0);
    check_eq("glitch_flag_cnt", 32'(flag_cnt), 32'd3);
    check_eq("glitch_data",     32'(rxd_data_o), 32'hFF);

    // Framing error followed by a held-low break
    send_frame(8'h3C, 1'b0);
    check_eq("brk_err_cnt",  32'(err_cnt), 32'd1);
    check_eq("brk_busy",     32'(rx_busy_o), 32'h1);
    wait_ticks(24);
    check_eq("brk_hold",     32'(rx_busy_o), 32'h1);
    rxd_i = 1'b1;
    wait_ticks(30);
    check_eq("brk_idle",     32'(rx_busy_o), 32'h0);
    check_eq("brk_err_once", 32'(err_cnt), 32'd1);
    check_eq("brk_flag_cnt", 32'(flag_cnt), 32'd3);
    check_eq("brk_data",     32'(rxd_data_o), 32'hFF);

    // Reset during data bit 4 of 0x5A
    rxd_i = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rxd_i = (i == 1 || i == 3) ? 1'b1 : 1'b0;
      wait_ticks(16);
    end
    rxd_i = 1'b1;
    wait_ticks(8);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ticks(40);
    check_eq("rst_idle",     32'(rx_busy_o), 32'h0);
    check_eq("rst_data",     32'(rxd_data_o), 32'h00);
    check_eq("rst_flag_cnt", 32'(flag_cnt), 32'd3);

    send_frame(8'h81, 1'b1);
    wait_ticks(4);
    check_eq("f81_flag_cnt", 32'(flag_cnt), 32'd4);
    check_eq("f81_data",     32'(rxd_data_o), 32'h81);

    // 0xFF with a one-tick low glitch on the centre sample of bit 0
    rxd_i = 1'b0;
    wait_ticks(16);
    rxd_i = 1'b1;
    wait_ticks(8);
    rxd_i = 1'b0;
    wait_ticks(1);
    rxd_i = 1'b1;
    wait_ticks(7);
    wait_ticks(16 * 8);
    wait_ticks(4);
    check_eq("mg_flag_cnt", 32'(flag_cnt), 32'd5);
`ifdef UART_RX_MAJORITY_EN
    check_eq("mg_data", 32'(rxd_data_o), 32'hFF);
`else
    check_eq("mg_data", 32'(rxd_data_o), 32'hFE);
`endif

    check_eq("strobe_overlap", 32'(both_cnt), 32'd0);
    check_eq("strobe_width",   32'(wide_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
